// File: rtl/vmem_pkg.sv
// Shared definitions for the byte-wide read bank: default geometry, FSM
// state encoding and the address range test used by both ports.
package vmem_pkg;

  localparam int VMEM_ADDR_W = 32;
  localparam int VMEM_DATA_W = 8;
  localparam int VMEM_IDX_W  = 8;
  localparam int VMEM_DEPTH  = 256;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } vmem_state_e;

  // An address is in range when every bit above the decoded index is zero.
  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input int unsigned idx_w);
    return (addr >> idx_w) == 64'd0;
  endfunction

endpackage

// File: rtl/vmem_rd_bank_if.sv
// Bus bundle between the read requester / write source (master) and the
// memory bank (slave).
interface vmem_rd_bank_if
  import vmem_pkg::*;
#(
  parameter int ADDR_W = VMEM_ADDR_W,
  parameter int DATA_W = VMEM_DATA_W
);

  logic [ADDR_W-1:0] mem_a_raddr;
  logic [DATA_W-1:0] mem_a_rdata;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              init_busy;
  logic              oor_err;

  modport master (
    output mem_a_raddr, wr_en, wr_addr, wr_data,
    input  mem_a_rdata, wr_ready, init_busy, oor_err
  );

  modport slave (
    input  mem_a_raddr, wr_en, wr_addr, wr_data,
    output mem_a_rdata, wr_ready, init_busy, oor_err
  );

endinterface

// File: rtl/vmem_array.sv
// Plain storage: one synchronous write port, one combinational read port.
// Contents are not reset; the owner clears them with a sweep.
module vmem_array
  import vmem_pkg::*;
#(
  parameter int DATA_W = VMEM_DATA_W,
  parameter int IDX_W  = VMEM_IDX_W,
  parameter int DEPTH  = VMEM_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Single write port, shared by the clear sweep and the pending-write commit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = mem_q[ridx];

endmodule

// File: rtl/vmem_rd_bank.sv
// Byte-wide memory bank behind the single-port read requester. Reads are
// combinational from the requester's registered address; writes go through a
// one-deep pending register that drains every cycle, with read forwarding so
// a write is visible the cycle after acceptance. After reset the whole array
// is cleared by a sweep before any write is accepted.
module vmem_rd_bank
  import vmem_pkg::*;
#(
  parameter int ADDR_W = VMEM_ADDR_W,
  parameter int DATA_W = VMEM_DATA_W,
  parameter int IDX_W  = VMEM_IDX_W,
  parameter int DEPTH  = VMEM_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  vmem_rd_bank_if.slave bus
);

  vmem_state_e       state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              pend_vld_q, pend_vld_d;
  logic [IDX_W-1:0]  pend_idx_q;
  logic [DATA_W-1:0] pend_data_q;
  logic              oor_q, oor_d;

  logic              wr_in_rng;
  logic              rd_in_rng;
  logic              wr_acc;
  logic [IDX_W-1:0]  rd_idx;
  logic              arr_we;
  logic [IDX_W-1:0]  arr_widx;
  logic [DATA_W-1:0] arr_wdata;
  logic [DATA_W-1:0] arr_rdata;
  logic [DATA_W-1:0] rdata;

  assign wr_in_rng = addr_in_range(64'(bus.wr_addr), IDX_W);
  assign rd_in_rng = addr_in_range(64'(bus.mem_a_raddr), IDX_W);
  assign rd_idx    = bus.mem_a_raddr[IDX_W-1:0];

  // Control state: FSM, sweep counter, pending-valid and sticky range error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= '0;
      pend_vld_q <= 1'b0;
      oor_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      pend_vld_q <= pend_vld_d;
      oor_q      <= oor_d;
    end
  end

  // Pending write payload; qualified by pend_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      pend_idx_q  <= bus.wr_addr[IDX_W-1:0];
      pend_data_q <= bus.wr_data;
    end
  end

  // Next state, write acceptance and array write-port mux (sweep vs commit).
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    pend_vld_d = 1'b0;
    oor_d      = oor_q;
    wr_acc     = 1'b0;
    arr_we     = 1'b0;
    arr_widx   = pend_idx_q;
    arr_wdata  = pend_data_q;
    case (state_q)
      ST_INIT: begin
        arr_we    = 1'b1;
        arr_widx  = clr_cnt_q;
        arr_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Commit whatever was captured last edge; a new capture may land on
        // the same edge and simply becomes the next commit.
        arr_we = pend_vld_q;
        if (bus.wr_en) begin
          if (wr_in_rng) begin
            wr_acc     = 1'b1;
            pend_vld_d = 1'b1;
          end else begin
            oor_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Read mux: zero while clearing or out of range, forward the pending write.
  always_comb begin
    rdata = '0;
    if (state_q == ST_RUN && rd_in_rng) begin
      if (pend_vld_q && pend_idx_q == rd_idx) begin
        rdata = pend_data_q;
      end else begin
        rdata = arr_rdata;
      end
    end
  end

  vmem_array #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk),
    .we     (arr_we),
    .widx   (arr_widx),
    .wdata  (arr_wdata),
    .ridx   (rd_idx),
    .rdata  (arr_rdata)
  );

  assign bus.mem_a_rdata = rdata;
  assign bus.wr_ready    = (state_q == ST_RUN);
  assign bus.init_busy   = (state_q == ST_INIT);
  assign bus.oor_err     = oor_q;

endmodule

// File: doc/vmem_rd_bank.md
Name: vmem_rd_bank

Overview:
- Byte-wide memory bank that sits directly downstream of the single-port read requester.
- Drives mem_a_rdata combinationally from the requester's registered mem_a_raddr, so data is valid in the requester's SEND_READ cycle.
- Owns a write port with a one-deep pending-write register and read forwarding.
- Runs a post-reset clear sweep that zeroes every entry before accepting writes.

Parameters:
- ADDR_W, 32, width of read and write addresses.
- DATA_W, 8, width of a memory entry.
- IDX_W, 8, index bits actually decoded.
- DEPTH, 256, number of entries; must equal 2**IDX_W.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_a_raddr  input  ADDR_W  read address from the requester; treated as always valid.
- mem_a_rdata  output  DATA_W  read data, combinational from mem_a_raddr and internal state.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- wr_ready  output  1  write accepted on an edge where wr_en && wr_ready.
- init_busy  output  1  clear sweep in progress.
- oor_err  output  1  sticky flag: an out-of-range write was accepted and dropped.

Behaviour:
- Reset (asserted asynchronously, released synchronously by the team's reset synchroniser upstream):
  - state = INIT, clr_cnt = 0, pend_vld = 0, oor_err = 0.
  - init_busy = 1, wr_ready = 0, mem_a_rdata = 0.
- State machine: INIT -> RUN when clr_cnt == DEPTH-1 at an edge. RUN holds until reset. No other transitions.
- INIT state:
  - Each edge writes 0 to entry clr_cnt, then increments clr_cnt.
  - The sweep takes exactly DEPTH edges after reset release, so init_busy falls after the DEPTH-th edge.
  - wr_ready = 0; wr_en is ignored and nothing is captured.
  - mem_a_rdata = 0 regardless of address.
- RUN state:
  - wr_ready = 1 constantly. The pending register drains every cycle, so there is never back-pressure.
- Write path (RUN only):
  - In range means wr_addr[ADDR_W-1:IDX_W] == 0.
  - Accepted in-range write: captures pend_idx = wr_addr[IDX_W-1:0], pend_data = wr_data, pend_vld = 1 at edge T.
  - Commit: array[pend_idx] <= pend_data at edge T+1.
  - pend_vld at T+1 reflects whether a new write was accepted on that edge; back-to-back writes commit in order.
  - Accepted out-of-range write: dropped (no array or pend change); oor_err <= 1 at that edge and stays 1 until reset.
- Read path:
  - Out of range (mem_a_raddr upper bits nonzero): returns 0.
  - Else if pend_vld && pend_idx == raddr index: returns pend_data (forwarding).
  - Else returns array[index].
- Read/write timing:
  - A read in the same cycle a write is presented returns the old value.
  - From the cycle after acceptance the new value is visible: via forwarding first, then via the array.
- Simultaneous events:
  - A commit and a new capture on the same edge are legal, including to the same index; the later write wins.
  - A write accepted on the last INIT edge is impossible, since wr_ready = 0 in INIT.
- Reset mid-operation:
  - The pending write is discarded.
  - The array is re-cleared by a full new sweep.
  - oor_err is cleared.

Decomposition:
- Shared package vmem_pkg holds:
  - state enum (INIT, RUN);
  - default ADDR_W, DATA_W, IDX_W, DEPTH constants;
  - a function returning the in-range test for an address.
- Sub-module vmem_array: storage only, with one synchronous write port (we, widx, wdata) and one combinational read port (ridx, rdata), no reset. The clear sweep drives its write port through a mux.

Test Plan:
- Reset release, idle:
  - init_busy stays 1 for 256 edges and is 0 after edge 256.
  - mem_a_raddr = 0x10 reads 0x00 throughout.
  - wr_ready goes 1 together with init_busy falling.
- After init, write 0x10 <= 0xA5 at cycle T, holding mem_a_raddr = 0x10:
  - rdata = 0x00 in cycle T;
  - 0xA5 in T+1 (forwarded);
  - 0xA5 in T+2 (array).
  - Requester-style read (raddr registered, then sampled one cycle later) captures 0xA5.
- Back-to-back writes 0x20 <= 0x11 then 0x20 <= 0x22, reading 0x20: reads 0x00, 0x11, 0x22 on successive cycles, then stable at 0x22.
- Write to 0x0000_0100 with data 0x55:
  - oor_err rises after that edge and stays 1.
  - Reads of 0x00 and 0x0000_0100 both return 0x00.
- Write 0x05 <= 0x77 pulsed during INIT: ignored; after init, read 0x05 returns 0x00 and oor_err = 0.
- Write 0x30 <= 0x99, then rst_n pulled low the next cycle (pending not yet committed) and released:
  - init_busy is 1 again for 256 edges;
  - read 0x30 returns 0x00;
  - oor_err = 0.
